// File: rtl/fir_interp_poly_2channel_pkg.sv
// fir_interp_poly_2channel_pkg: shared constants, state encodings and helpers for the 2-channel interpolator
package fir_interp_poly_2channel_pkg;
   localparam int N_TAPS         = 32;
   localparam int L              = 4;
   localparam int L_LOG2         = 2;
   localparam int BANK_LEN       = 8;
   localparam int BANK_LEN_LOG2  = 3;
   localparam int INPUT_WIDTH    = 14;
   localparam int TAP_WIDTH      = 16;
   localparam int INTERNAL_WIDTH = 34;
   localparam int NORM_SHIFT     = 15;
   localparam int OUTPUT_WIDTH   = 14;
   localparam int OUT_SPACING    = 20;
   localparam int PROD_WIDTH     = INPUT_WIDTH + TAP_WIDTH;
   localparam int SPACE_W        = $clog2(OUT_SPACING);
   localparam int ADDR_W         = L_LOG2 + BANK_LEN_LOG2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   localparam logic signed [INTERNAL_WIDTH-1:0] RND  = INTERNAL_WIDTH'(2 ** (NORM_SHIFT - 1));
   localparam logic signed [INTERNAL_WIDTH-1:0] OMAX = INTERNAL_WIDTH'(2 ** (OUTPUT_WIDTH - 1) - 1);
   localparam logic signed [INTERNAL_WIDTH-1:0] OMIN = INTERNAL_WIDTH'(-(2 ** (OUTPUT_WIDTH - 1)));

   typedef logic [N_TAPS*TAP_WIDTH-1:0] taps_t;

   // default prototype: ramp h[i] = 256*i
   function automatic taps_t ramp_taps();
      taps_t t;
      t = '0;
      for (int i = 0; i < N_TAPS; i++) t[i*TAP_WIDTH +: TAP_WIDTH] = TAP_WIDTH'(256 * i);
      return t;
   endfunction

   // round half up, shift down to output scale, clamp to the output range
   function automatic logic signed [OUTPUT_WIDTH-1:0] round_sat(input logic signed [INTERNAL_WIDTH-1:0] acc);
      logic signed [INTERNAL_WIDTH-1:0] s;
      s = (acc + RND) >>> NORM_SHIFT;
      return s > OMAX ? OMAX[OUTPUT_WIDTH-1:0] : s < OMIN ? OMIN[OUTPUT_WIDTH-1:0] : s[OUTPUT_WIDTH-1:0];
   endfunction
endpackage

// File: rtl/fir_interp_poly_2channel_tap_rom.sv
// fir_interp_poly_2channel_tap_rom: polyphase tap ROM shared by both channels, synchronous read at {phase, k}
module fir_interp_poly_2channel_tap_rom
   import fir_interp_poly_2channel_pkg::*;
#(
   parameter taps_t TAPS = ramp_taps()
) (
   input  logic                        clk,
   input  logic [ADDR_W-1:0]           i_addr,
   output logic signed [TAP_WIDTH-1:0] o_tap
);
   logic [TAP_WIDTH-1:0] w_rom [N_TAPS];
   logic [ADDR_W-1:0]    w_idx;
   // bank p entry k is prototype tap k*L+p, which is just the index {k, p}
   assign w_idx = {i_addr[BANK_LEN_LOG2-1:0], i_addr[ADDR_W-1 -: L_LOG2]};
   for (genvar g = 0; g < N_TAPS; g++) begin : g_rom
      assign w_rom[g] = TAPS[g*TAP_WIDTH +: TAP_WIDTH];
   end
   // one-cycle registered read
   always_ff @(posedge clk) o_tap <= w_rom[w_idx];
endmodule

// File: rtl/fir_interp_poly_2channel.sv
// fir_interp_poly_2channel: 2-channel polyphase x L interpolator with shared taps and control, one MAC per channel
module fir_interp_poly_2channel
   import fir_interp_poly_2channel_pkg::*;
#(
   parameter taps_t TAPS = ramp_taps()
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           din_valid,
   input  logic signed [INPUT_WIDTH-1:0]  din_a,
   input  logic signed [INPUT_WIDTH-1:0]  din_b,
   output logic signed [OUTPUT_WIDTH-1:0] dout_a,
   output logic signed [OUTPUT_WIDTH-1:0] dout_b,
   output logic                           dout_valid,
   output logic                           busy,
   output logic                           overrun
);
   logic [1:0]                       r_state, w_next;
   logic [L_LOG2-1:0]                r_phase;
   logic [BANK_LEN_LOG2:0]           r_k;
   logic [SPACE_W-1:0]               r_space;
   logic signed [INPUT_WIDTH-1:0]    r_xa [BANK_LEN];
   logic signed [INPUT_WIDTH-1:0]    r_xb [BANK_LEN];
   logic signed [INPUT_WIDTH-1:0]    r_sel_a, r_sel_b;
   logic                             r_acc_en;
   logic signed [INTERNAL_WIDTH-1:0] r_acc_a, r_acc_b;
   logic signed [OUTPUT_WIDTH-1:0]   r_dout_a, r_dout_b;
   logic                             r_dout_valid, r_overrun;
   logic signed [TAP_WIDTH-1:0]      w_tap;
   logic signed [PROD_WIDTH-1:0]     w_prod_a, w_prod_b;
   logic                             w_accept, w_start, w_mac_last;

   assign w_accept   = din_valid && r_state == S_IDLE;
   assign w_start    = w_accept || (r_state == S_WAIT && r_space == SPACE_W'(OUT_SPACING - 1));
   assign w_mac_last = r_k == (BANK_LEN_LOG2 + 1)'(BANK_LEN);
   assign w_prod_a   = r_sel_a * w_tap;
   assign w_prod_b   = r_sel_b * w_tap;

   fir_interp_poly_2channel_tap_rom #(.TAPS(TAPS)) u_rom (
      .clk   (clk),
      .i_addr({r_phase, r_k[BANK_LEN_LOG2-1:0]}),
      .o_tap (w_tap)
   );

   // next state; MAC runs one extra drain cycle to absorb the ROM read latency
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_MAC : S_IDLE;
         S_MAC:   w_next = w_mac_last ? S_ROUND : S_MAC;
         S_ROUND: w_next = r_phase == L_LOG2'(L - 1) ? S_IDLE : S_WAIT;
         default: w_next = w_start ? S_MAC : S_WAIT;
      endcase
   end

   // control: state, phase, tap index and output-spacing counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_k     <= '0;
         r_space <= '0;
      end else begin
         r_state <= w_next;
         r_phase <= w_accept ? '0 : r_state == S_ROUND ? r_phase + 1'b1 : r_phase;
         r_k     <= r_state == S_MAC ? r_k + 1'b1 : '0;
         r_space <= w_start ? '0 : r_space + 1'b1;
      end
   end

   // datapath: delay lines, MAC pipelines, rounded outputs and sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BANK_LEN; i++) begin
            r_xa[i] <= '0;
            r_xb[i] <= '0;
         end
         r_sel_a      <= '0;
         r_sel_b      <= '0;
         r_acc_en     <= 1'b0;
         r_acc_a      <= '0;
         r_acc_b      <= '0;
         r_dout_a     <= '0;
         r_dout_b     <= '0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_xa[0] <= din_a;
            r_xb[0] <= din_b;
            for (int i = 1; i < BANK_LEN; i++) begin
               r_xa[i] <= r_xa[i-1];
               r_xb[i] <= r_xb[i-1];
            end
         end
         r_sel_a      <= r_xa[r_k[BANK_LEN_LOG2-1:0]];
         r_sel_b      <= r_xb[r_k[BANK_LEN_LOG2-1:0]];
         r_acc_en     <= r_state == S_MAC && !w_mac_last;
         r_acc_a      <= w_start ? '0 : r_acc_en ? r_acc_a + INTERNAL_WIDTH'(w_prod_a) : r_acc_a;
         r_acc_b      <= w_start ? '0 : r_acc_en ? r_acc_b + INTERNAL_WIDTH'(w_prod_b) : r_acc_b;
         r_dout_a     <= r_state == S_ROUND ? round_sat(r_acc_a) : r_dout_a;
         r_dout_b     <= r_state == S_ROUND ? round_sat(r_acc_b) : r_dout_b;
         r_dout_valid <= r_state == S_ROUND;
         r_overrun    <= r_overrun || (din_valid && r_state != S_IDLE);
      end
   end

   assign dout_a     = r_dout_a;
   assign dout_b     = r_dout_b;
   assign dout_valid = r_dout_valid;
   assign busy       = r_state != S_IDLE || r_dout_valid;
   assign overrun    = r_overrun;
endmodule

// File: tb/tb_fir_interp_poly_2channel.sv
// tb_fir_interp_poly_2channel: directed bench with scoreboard for ramp-tap and full-scale-tap instances
module tb_fir_interp_poly_2channel;
   typedef struct {int a; int b;} exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_valid = 1'b0;
   logic signed [13:0] din_a = '0, din_b = '0;
   logic signed [13:0] ra, rb, sa, sb;
   logic rdv, sdv, rbusy, sbusy, rovr, sovr;

   int checks = 0;
   int errors = 0;
   int ma [8];
   int mb [8];
   bit imp = 1'b0;
   int m = 0;
   exp_t qr [$];
   exp_t qs [$];
   exp_t er, es;

   fir_interp_poly_2channel dut_r (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_a(din_a), .din_b(din_b),
      .dout_a(ra), .dout_b(rb), .dout_valid(rdv), .busy(rbusy), .overrun(rovr)
   );

   fir_interp_poly_2channel #(.TAPS({32{16'h7FFF}})) dut_s (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_a(din_a), .din_b(din_b),
      .dout_a(sa), .dout_b(sb), .dout_valid(sdv), .busy(sbusy), .overrun(sovr)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int rs(input longint acc);
      longint s;
      s = (acc + 16384) >>> 15;
      return s > 8191 ? 8191 : s < -8192 ? -8192 : int'(s);
   endfunction

   function automatic exp_t mdl(input int p, input bit full);
      longint aa, ab;
      exp_t e;
      aa = 0;
      ab = 0;
      for (int k = 0; k < 8; k++) begin
         aa += longint'(ma[k]) * (full ? 32767 : 256 * (k * 4 + p));
         ab += longint'(mb[k]) * (full ? 32767 : 256 * (k * 4 + p));
      end
      e.a = rs(aa);
      e.b = rs(ab);
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic drive(input int a, input int b, input bit acc);
      din_valid = 1'b1;
      din_a = 14'(a);
      din_b = 14'(b);
      if (acc) begin
         for (int k = 7; k > 0; k--) begin
            ma[k] = ma[k-1];
            mb[k] = mb[k-1];
         end
         ma[0] = a;
         mb[0] = b;
         for (int p = 0; p < 4; p++) begin
            qr.push_back(imp ? '{64 * m, -64 * m} : mdl(p, 1'b0));
            qs.push_back(mdl(p, 1'b1));
            if (imp) m++;
         end
      end
   endtask

   // scoreboard: every dout_valid must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst) begin
         if (rdv) begin
            if (qr.size() == 0) chk("unexpected_dv_r", 1, 0);
            else begin
               er = qr.pop_front();
               chk("r_dout_a", ra, er.a);
               chk("r_dout_b", rb, er.b);
            end
         end
         if (sdv) begin
            if (qs.size() == 0) chk("unexpected_dv_s", 1, 0);
            else begin
               es = qs.pop_front();
               chk("s_dout_a", sa, es.a);
               chk("s_dout_b", sb, es.b);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 8; k++) begin
         ma[k] = 0;
         mb[k] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_dout_a", ra, 0);
      chk("rst_dout_b", rb, 0);
      chk("rst_dv", rdv, 0);
      chk("rst_busy", rbusy, 0);
      chk("rst_overrun", rovr, 0);
      chk("rst_s_dout_a", sa, 0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_dv", rdv, 0);
         chk("idle_busy", rbusy, 0);
      end

      imp = 1'b1;
      for (int n = 0; n < 8; n++) begin
         drive(n == 0 ? 8191 : 0, n == 0 ? -8192 : 0, 1'b1);
         for (int c = 1; c <= 71; c++) begin
            tick();
            chk("lat_dv", rdv, c == 11 || c == 31 || c == 51 || c == 71);
            chk("lat_dv_s", sdv, c == 11 || c == 31 || c == 51 || c == 71);
            chk("lat_busy", rbusy, 1);
         end
      end
      imp = 1'b0;
      tick();
      chk("busy_fall", rbusy, 0);
      chk("dv_after_burst", rdv, 0);

      for (int n = 0; n < 8; n++) begin
         drive(8191, -8192, 1'b1);
         repeat (71) tick();
      end
      tick();
      chk("sat_pos", sa, 8191);
      chk("sat_neg", sb, -8192);
      chk("sat_busy", sbusy, 0);

      chk("ovr_clear", rovr, 0);
      drive(100, -100, 1'b1);
      for (int c = 1; c <= 75; c++) begin
         tick();
         if (c == 5) begin
            chk("ovr_before", rovr, 0);
            drive(5000, 5000, 1'b0);
         end
         if (c >= 6) chk("ovr_set", rovr, 1);
         chk("ovr_dv", rdv, c == 11 || c == 31 || c == 51 || c == 71);
      end
      chk("ovr_set_s", sovr, 1);

      drive(3000, -3000, 1'b1);
      for (int c = 1; c <= 40; c++) tick();
      rst = 1'b1;
      qr.delete();
      qs.delete();
      for (int k = 0; k < 8; k++) begin
         ma[k] = 0;
         mb[k] = 0;
      end
      tick();
      chk("mid_rst_dout_a", ra, 0);
      chk("mid_rst_dout_b", rb, 0);
      chk("mid_rst_busy", rbusy, 0);
      chk("mid_rst_overrun", rovr, 0);
      rst = 1'b0;
      for (int c = 42; c <= 75; c++) begin
         tick();
         chk("no_dv_after_rst", rdv, 0);
         chk("no_dv_after_rst_s", sdv, 0);
      end

      drive(1000, -1000, 1'b1);
      for (int c = 1; c <= 75; c++) begin
         tick();
         chk("post_rst_dv", rdv, c == 11 || c == 31 || c == 51 || c == 71);
      end
      chk("qr_drained", qr.size(), 0);
      chk("qs_drained", qs.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
